// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding, register indices, reset values and R/W bit position shared by i2c_target_regs
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK,
        IGNORE
    } i2c_state_t;

    localparam logic [2:0] REG_ENABLE = 3'd0;
    localparam logic [2:0] REG_ATIME  = 3'd1;
    localparam logic [2:0] REG_SCR2   = 3'd2;
    localparam logic [2:0] REG_SCR3   = 3'd3;
    localparam logic [2:0] REG_CDATAL = 3'd4;
    localparam logic [2:0] REG_CDATAH = 3'd5;
    localparam logic [2:0] REG_ID     = 3'd6;
    localparam logic [2:0] REG_SCR7   = 3'd7;

    localparam logic [7:0] ENABLE_RST = 8'h00;
    localparam logic [7:0] ATIME_RST  = 8'hFF;
    localparam logic [7:0] SCR_RST    = 8'h00;

    localparam int RW_BIT = 0;

    function automatic logic reg_writable(input logic [2:0] idx);
        return !(idx inside {REG_CDATAL, REG_CDATAH, REG_ID});
    endfunction

    function automatic logic [7:0] reg_rst(input logic [2:0] idx);
        return idx == REG_ENABLE ? ENABLE_RST : idx == REG_ATIME ? ATIME_RST : SCR_RST;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: 2-flop synchronizer for an asynchronous bus line plus one edge-detect flop
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [2:0] s;

    // idle bus lines are pulled high, so the pipeline resets to 1 and sees no edge on release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) s <= 3'b111;
        else      s <= {s[1:0], d};
    end

    assign q    = s[1];
    assign rise = s[1] & ~s[2];
    assign fall = ~s[1] & s[2];

endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with an 8-entry TCS3502-style register map; define I2C_TARGET_AUTOINC_EN for pointer auto-increment
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h29,
    parameter logic [7:0] DEV_ID   = 8'h44
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] sense_data,
    output logic [7:0]  enable_reg,
    output logic        wr_strobe,
    output logic [2:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    logic       scl_q, scl_rise, scl_fall;
    logic       sda_q, sda_rise, sda_fall;
    logic       start_c, stop_c;
    i2c_state_t state;
    logic [3:0] cnt;
    logic [7:0] sh;
    logic [2:0] ptr, ptr_nx;
    logic       rw, mack;
    logic [7:0] cdatah_shadow;
    logic [7:0] regs [8];
    logic [7:0] rd_byte;

    i2c_sync_edge u_scl (.clk(clk), .rst(rst), .d(scl_in), .q(scl_q), .rise(scl_rise), .fall(scl_fall));
    i2c_sync_edge u_sda (.clk(clk), .rst(rst), .d(sda_in), .q(sda_q), .rise(sda_rise), .fall(sda_fall));

    assign start_c    = scl_q & sda_fall;
    assign stop_c     = scl_q & sda_rise;
    assign enable_reg = regs[REG_ENABLE];

`ifdef I2C_TARGET_AUTOINC_EN
    assign ptr_nx = ptr + 3'd1;
`else
    assign ptr_nx = ptr;
`endif

    // byte presented for the next read; CDATAH comes from the shadow so both halves match
    assign rd_byte = ptr == REG_CDATAL ? sense_data[7:0] :
                     ptr == REG_CDATAH ? cdatah_shadow :
                     ptr == REG_ID     ? DEV_ID : regs[ptr];

    // bus protocol FSM: bits sampled on SCL rise, SDA driven only on SCL fall, START/STOP override all
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            sh            <= 8'h00;
            ptr           <= 3'd0;
            rw            <= 1'b0;
            mack          <= 1'b0;
            sda_oe        <= 1'b0;
            busy          <= 1'b0;
            wr_strobe     <= 1'b0;
            wr_addr       <= 3'd0;
            wr_data       <= 8'h00;
            cdatah_shadow <= 8'h00;
            for (int i = 0; i < 8; i++) regs[i] <= reg_rst(3'(i));
        end else begin
            wr_strobe <= 1'b0;
            if (stop_c) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_c) begin
                state  <= ADDR;
                cnt    <= 4'd0;
                sda_oe <= 1'b0;
            end else if (scl_rise) begin
                if (state inside {ADDR, PTR, WDATA}) begin
                    sh  <= {sh[6:0], sda_q};
                    cnt <= cnt + 4'd1;
                end
                if (state == RACK) mack <= ~sda_q;
            end else if (scl_fall) begin
                case (state)
                    ADDR: if (cnt == 4'd8) begin
                        cnt <= 4'd0;
                        if (sh[7:1] == DEV_ADDR) begin
                            state  <= ADDR_ACK;
                            sda_oe <= 1'b1;
                            busy   <= 1'b1;
                            rw     <= sh[RW_BIT];
                        end else begin
                            state <= IGNORE;
                        end
                    end
                    ADDR_ACK: begin
                        cnt <= 4'd0;
                        if (rw) begin
                            state  <= RDATA;
                            sh     <= rd_byte;
                            sda_oe <= ~rd_byte[7];
                            if (ptr == REG_CDATAL) cdatah_shadow <= sense_data[15:8];
                        end else begin
                            state  <= PTR;
                            sda_oe <= 1'b0;
                        end
                    end
                    PTR: if (cnt == 4'd8) begin
                        state  <= PTR_ACK;
                        sda_oe <= 1'b1;
                        ptr    <= sh[2:0];
                    end
                    PTR_ACK: begin
                        state  <= WDATA;
                        sda_oe <= 1'b0;
                        cnt    <= 4'd0;
                    end
                    WDATA: if (cnt == 4'd8) begin
                        state  <= WDATA_ACK;
                        sda_oe <= 1'b1;
                    end
                    WDATA_ACK: begin
                        if (reg_writable(ptr)) begin
                            regs[ptr] <= sh;
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr;
                            wr_data   <= sh;
                        end
                        ptr    <= ptr_nx;
                        state  <= WDATA;
                        sda_oe <= 1'b0;
                        cnt    <= 4'd0;
                    end
                    RDATA: if (cnt == 4'd7) begin
                        state  <= RACK;
                        sda_oe <= 1'b0;
                        ptr    <= ptr_nx;
                    end else begin
                        cnt    <= cnt + 4'd1;
                        sh     <= {sh[6:0], 1'b0};
                        sda_oe <= ~sh[6];
                    end
                    RACK: if (mack) begin
                        state  <= RDATA;
                        cnt    <= 4'd0;
                        sh     <= rd_byte;
                        sda_oe <= ~rd_byte[7];
                        if (ptr == REG_CDATAL) cdatah_shadow <= sense_data[15:8];
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bus-level master driving i2c_target_regs, table vectors, corner sequences and a randomized register model
module tb_i2c_target_regs;

    localparam int Q = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic        sda_oe;
    logic [15:0] sense = 16'h0000;
    logic [7:0]  enable_reg;
    logic        wr_strobe;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    logic [10:0] obs_q[$];
    logic [10:0] exp_q[$];
    logic        oe_seen = 1'b0;

    logic [7:0] mregs [8];
    logic [2:0] mptr;
    logic [7:0] mshh;
    logic       shv;

    typedef struct {
        logic       wr;
        logic [7:0] ptr;
        logic [7:0] val;
        logic       strobe;
    } vec_t;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs dut (
        .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
        .sense_data(sense), .enable_reg(enable_reg), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always @(negedge clk) begin
        if (wr_strobe) obs_q.push_back({wr_addr, wr_data});
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hp();
        repeat (Q) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; hp(); scl = 1'b1; hp(); hp(); scl = 1'b0; hp();
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; hp(); scl = 1'b1; hp(); b = sda_bus; hp(); scl = 1'b0; hp();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; hp(); scl = 1'b1; hp(); sda_m = 1'b0; hp(); scl = 1'b0; hp();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; hp(); scl = 1'b1; hp(); sda_m = 1'b1; hp(); hp();
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic rd_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack);
    endtask

    task automatic tx_ptr(input logic [7:0] p);
        logic a;
        i2c_start();
        wr_byte(8'h52, a); chk("waddr_ack", 32'(a), 1);
        wr_byte(p, a);     chk("ptr_ack", 32'(a), 1);
    endtask

    task automatic wr_data_b(input logic [7:0] d);
        logic a;
        wr_byte(d, a); chk("data_ack", 32'(a), 1);
    endtask

    task automatic rd_start();
        logic a;
        i2c_start();
        wr_byte(8'h53, a); chk("raddr_ack", 32'(a), 1);
    endtask

    task automatic chk_strobes();
        chk("strobe_count", 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) chk("strobe_addr_data", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        obs_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [2:0] nxt(input logic [2:0] p);
`ifdef I2C_TARGET_AUTOINC_EN
        return p + 3'd1;
`else
        return p;
`endif
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) mregs[i] = (i == 1) ? 8'hFF : 8'h00;
        mptr = 3'd0;
        shv  = 1'b0;
    endtask

    task automatic m_wr(input logic [7:0] d);
        if (!(mptr inside {3'd4, 3'd5, 3'd6})) begin
            mregs[mptr] = d;
            exp_q.push_back({mptr, d});
        end
        mptr = nxt(mptr);
    endtask

    task automatic m_rd(output logic [7:0] v, output logic known);
        known = !(mptr == 3'd5 && !shv);
        case (mptr)
            3'd4: begin mshh = sense[15:8]; shv = 1'b1; v = sense[7:0]; end
            3'd5: v = mshh;
            3'd6: v = 8'h44;
            default: v = mregs[mptr];
        endcase
        mptr = nxt(mptr);
    endtask

    initial begin
        vec_t       tbl [11];
        logic [7:0] v, v2, e, p, d;
        logic       a, known;
        int         kind, n;

        tbl = '{
            '{1'b1, 8'h01, 8'hA5, 1'b1}, '{1'b0, 8'h01, 8'hA5, 1'b0},
            '{1'b1, 8'h0A, 8'h3C, 1'b1}, '{1'b0, 8'h02, 8'h3C, 1'b0},
            '{1'b1, 8'h07, 8'h81, 1'b1}, '{1'b0, 8'hF7, 8'h81, 1'b0},
            '{1'b1, 8'h05, 8'h11, 1'b0}, '{1'b0, 8'h00, 8'h03, 1'b0},
            '{1'b1, 8'h03, 8'hFF, 1'b1}, '{1'b0, 8'h03, 8'hFF, 1'b0},
            '{1'b0, 8'h06, 8'h44, 1'b0}
        };

        repeat (4) @(negedge clk);
        rst = 1'b1;
        hp();
        chk("rst_sda_oe", 32'(sda_oe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_strobe", 32'(wr_strobe), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_enable", 32'(enable_reg), 0);

        tx_ptr(8'h00);
        chk("busy_in_txn", 32'(busy), 1);
        wr_data_b(8'h03);
        i2c_stop();
        chk("busy_after_stop", 32'(busy), 0);
        chk("enable_strobes", 32'(obs_q.size()), 1);
        if (obs_q.size() > 0) chk("enable_strobe_val", 32'(obs_q[0]), 32'({3'd0, 8'h03}));
        chk("enable_reg", 32'(enable_reg), 32'h03);
        obs_q.delete();

        oe_seen = 1'b0;
        i2c_start();
        wr_byte(8'h54, a);
        chk("wrong_addr_ack", 32'(a), 0);
        chk("wrong_addr_busy", 32'(busy), 0);
        wr_byte(8'h00, a);
        wr_byte(8'h77, a);
        i2c_stop();
        chk("wrong_addr_oe", 32'(oe_seen), 0);
        chk("wrong_addr_strobes", 32'(obs_q.size()), 0);
        chk("wrong_addr_enable", 32'(enable_reg), 32'h03);

        for (int i = 0; i < 11; i++) begin
            obs_q.delete();
            tx_ptr(tbl[i].ptr);
            if (tbl[i].wr) begin
                wr_data_b(tbl[i].val);
                i2c_stop();
                chk("tbl_strobe_count", 32'(obs_q.size()), 32'(tbl[i].strobe));
                if (obs_q.size() > 0) chk("tbl_strobe_val", 32'(obs_q[0]), 32'({tbl[i].ptr[2:0], tbl[i].val}));
            end else begin
                rd_start();
                rd_byte(1'b0, v);
                i2c_stop();
                chk("tbl_read", 32'(v), 32'(tbl[i].val));
            end
        end

        sense = 16'hBEEF;
        tx_ptr(8'h04);
        rd_start();
        rd_byte(1'b1, v);
`ifdef I2C_TARGET_AUTOINC_EN
        sense = 16'h1234;
`endif
        rd_byte(1'b0, v2);
        chk("busy_after_nack", 32'(busy), 0);
        i2c_stop();
        chk("cdata_byte0", 32'(v), 32'hEF);
`ifdef I2C_TARGET_AUTOINC_EN
        chk("cdata_byte1", 32'(v2), 32'hBE);
`else
        chk("cdata_byte1", 32'(v2), 32'hEF);
`endif

        obs_q.delete();
        tx_ptr(8'h06);
        wr_data_b(8'h99);
        i2c_stop();
        chk("id_write_strobes", 32'(obs_q.size()), 0);
        tx_ptr(8'h06);
        rd_start();
        rd_byte(1'b0, v);
        i2c_stop();
        chk("id_read", 32'(v), 32'h44);

        tx_ptr(8'h01);
        wr_data_b(8'h5A);
        i2c_stop();
        obs_q.delete();
        tx_ptr(8'h00);
        rd_start();
        chk("oe_before_rst", 32'(sda_oe), 1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 chk("oe_async_rst", 32'(sda_oe), 0);
        scl = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        hp();
        chk("post_rst_enable_out", 32'(enable_reg), 0);
        tx_ptr(8'h00);
        rd_start();
        rd_byte(1'b0, v);
        i2c_stop();
        chk("post_rst_enable", 32'(v), 32'h00);
        tx_ptr(8'h01);
        rd_start();
        rd_byte(1'b0, v);
        i2c_stop();
        chk("post_rst_atime", 32'(v), 32'hFF);

        m_reset();
        mptr = nxt(3'd1);
        obs_q.delete();
        for (int t = 0; t < 24; t++) begin
            kind  = $urandom_range(0, 2);
            n     = $urandom_range(1, 3);
            p     = 8'($urandom);
            sense = 16'($urandom);
            if (kind == 0) begin
                tx_ptr(p);
                mptr = p[2:0];
                for (int k = 0; k < n; k++) begin
                    d = 8'($urandom);
                    wr_data_b(d);
                    m_wr(d);
                end
                i2c_stop();
                chk_strobes();
            end else begin
                if (kind == 1) begin
                    tx_ptr(p);
                    mptr = p[2:0];
                end
                rd_start();
                for (int k = 0; k < n; k++) begin
                    m_rd(e, known);
                    rd_byte(k < n - 1, v);
                    if (known) chk("rand_read", 32'(v), 32'(e));
                end
                i2c_stop();
                chk("rand_read_strobes", 32'(obs_q.size()), 0);
                obs_q.delete();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
